// File: rtl/normal_multiplier_if.sv
// normal_multiplier_if: operand/product bus of the GF(4) normal-basis multiplier.
interface normal_multiplier_if;
    logic       in_valid;
    logic [1:0] x;
    logic [1:0] y;
    logic [1:0] result;
    logic       out_valid;
    modport master (output in_valid, x, y, input result, out_valid);
    modport slave (input in_valid, x, y, output result, out_valid);
endinterface

// File: rtl/normal_multiplier.sv
// normal_multiplier: GF(2^2) product in normal basis {W^2, W}, pipelined LATENCY stages with a valid chain.
module normal_multiplier #(
    parameter int LATENCY = 1
) (
    input  logic                clk,
    input  logic                rst_n,
    normal_multiplier_if.slave  bus
);
    if (LATENCY < 1 || LATENCY > 4) begin : g_bad_latency
        $error("normal_multiplier: LATENCY must be in 1..4");
    end
    logic                        t;
    logic [1:0]                  prod;
    logic [LATENCY-1:0][1:0]     data_q;
    logic [LATENCY-1:0]          valid_q;
    // t is the shared cross term; adding it to both coefficients folds in the W*W^2 = 1 terms
    assign t    = (bus.x[1] ^ bus.x[0]) & (bus.y[1] ^ bus.y[0]);
    assign prod = {(bus.x[1] & bus.y[1]) ^ t, (bus.x[0] & bus.y[0]) ^ t};
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_q  <= '0;
            valid_q <= '0;
        end else begin
            data_q[0]  <= prod;
            valid_q[0] <= bus.in_valid;
            for (int i = 1; i < LATENCY; i++) begin
                data_q[i]  <= data_q[i-1];
                valid_q[i] <= valid_q[i-1];
            end
        end
    end
    assign bus.result    = data_q[LATENCY-1];
    assign bus.out_valid = valid_q[LATENCY-1];
endmodule

// File: tb/tb_normal_multiplier.sv
// tb_normal_multiplier: directed checks of three multiplier instances (LATENCY 1, 3, 4) sharing clock and reset.
module tb_normal_multiplier;
    logic clk;
    logic rst_n;
    int   n_checks = 0;
    int   n_pass   = 0;

    normal_multiplier_if b1 ();
    normal_multiplier_if b3 ();
    normal_multiplier_if b4 ();

    normal_multiplier #(.LATENCY(1)) u1 (.clk(clk), .rst_n(rst_n), .bus(b1));
    normal_multiplier #(.LATENCY(3)) u3 (.clk(clk), .rst_n(rst_n), .bus(b3));
    normal_multiplier #(.LATENCY(4)) u4 (.clk(clk), .rst_n(rst_n), .bus(b4));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [1:0] obs, input logic [1:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    endtask

    task automatic drive(input logic v, input logic [1:0] a, input logic [1:0] b);
        b1.in_valid = v; b1.x = a; b1.y = b;
        b3.in_valid = v; b3.x = a; b3.y = b;
        b4.in_valid = v; b4.x = a; b4.y = b;
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    logic [1:0] sweep [16] = '{2'b00, 2'b00, 2'b00, 2'b00,
                               2'b00, 2'b10, 2'b11, 2'b01,
                               2'b00, 2'b11, 2'b01, 2'b10,
                               2'b00, 2'b01, 2'b10, 2'b11};
    logic       vpat [6] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};

    initial begin
        // reset held with x = y = 1
        rst_n = 1'b0;
        drive(1'b1, 2'b11, 2'b11);
        #1;
        chk("rst_res1", b1.result, 2'b00);
        chk("rst_ov1", {1'b0, b1.out_valid}, 2'b00);
        chk("rst_ov4", {1'b0, b4.out_valid}, 2'b00);
        cyc();
        cyc();
        chk("rst_hold_res1", b1.result, 2'b00);
        chk("rst_hold_ov3", {1'b0, b3.out_valid}, 2'b00);
        @(negedge clk);
        rst_n = 1'b1;
        for (int e = 1; e <= 4; e++) begin
            cyc();
            chk($sformatf("rel_res1_e%0d", e), b1.result, 2'b11);
            chk($sformatf("rel_ov1_e%0d", e), {1'b0, b1.out_valid}, 2'b01);
            chk($sformatf("rel_res3_e%0d", e), b3.result, (e >= 3) ? 2'b11 : 2'b00);
            chk($sformatf("rel_ov3_e%0d", e), {1'b0, b3.out_valid}, {1'b0, e >= 3});
            chk($sformatf("rel_ov4_e%0d", e), {1'b0, b4.out_valid}, {1'b0, e >= 4});
        end

        // exhaustive back-to-back sweep
        for (int i = 0; i < 16; i++) begin
            logic [3:0] iv;
            iv = 4'(i);
            drive(1'b1, iv[3:2], iv[1:0]);
            cyc();
            chk($sformatf("sweep1_%0d", i), b1.result, sweep[i]);
            chk($sformatf("sweep_ov1_%0d", i), {1'b0, b1.out_valid}, 2'b01);
            if (i >= 3) chk($sformatf("sweep4_%0d", i), b4.result, sweep[i-3]);
        end

        // identity and commutativity
        drive(1'b1, 2'b11, 2'b10); cyc(); chk("id_11x10", b1.result, 2'b10);
        drive(1'b1, 2'b10, 2'b11); cyc(); chk("id_10x11", b1.result, 2'b10);
        drive(1'b1, 2'b01, 2'b10); cyc(); chk("com_01x10", b1.result, 2'b11);
        drive(1'b1, 2'b10, 2'b01); cyc(); chk("com_10x01", b1.result, 2'b11);

        // valid tracking with constant W*W operands
        for (int j = 0; j < 6; j++) begin
            drive(vpat[j], 2'b01, 2'b01);
            cyc();
            chk($sformatf("vt_ov1_%0d", j), {1'b0, b1.out_valid}, {1'b0, vpat[j]});
            chk($sformatf("vt_res1_%0d", j), b1.result, 2'b10);
            if (j >= 2) begin
                chk($sformatf("vt_ov3_%0d", j), {1'b0, b3.out_valid}, {1'b0, vpat[j-2]});
                chk($sformatf("vt_res3_%0d", j), b3.result, 2'b10);
            end
        end

        // single pulse through the 3-stage pipe
        drive(1'b0, 2'b00, 2'b00);
        repeat (4) cyc();
        drive(1'b1, 2'b10, 2'b10);
        for (int j = 0; j < 6; j++) begin
            cyc();
            drive(1'b0, 2'b00, 2'b00);
            chk($sformatf("lat_ov1_%0d", j), {1'b0, b1.out_valid}, {1'b0, j == 0});
            chk($sformatf("lat_ov3_%0d", j), {1'b0, b3.out_valid}, {1'b0, j == 2});
            if (j == 2) chk("lat_res3", b3.result, 2'b01);
        end

        // mid-stream asynchronous reset with products in flight
        drive(1'b1, 2'b11, 2'b11);
        repeat (4) cyc();
        chk("mid_pre_ov4", {1'b0, b4.out_valid}, 2'b01);
        chk("mid_pre_res4", b4.result, 2'b11);
        drive(1'b0, 2'b00, 2'b00);
        #1;
        rst_n = 1'b0;
        #1;
        chk("mid_ov4", {1'b0, b4.out_valid}, 2'b00);
        chk("mid_res4", b4.result, 2'b00);
        chk("mid_ov1", {1'b0, b1.out_valid}, 2'b00);
        chk("mid_res3", b3.result, 2'b00);
        #4;
        rst_n = 1'b1;
        for (int j = 0; j < 5; j++) begin
            cyc();
            chk($sformatf("post_ov4_%0d", j), {1'b0, b4.out_valid}, 2'b00);
            chk($sformatf("post_res4_%0d", j), b4.result, 2'b00);
            chk($sformatf("post_ov3_%0d", j), {1'b0, b3.out_valid}, 2'b00);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
